// File: rtl/psdsqrt_arbiter.sv
// rtl/psdsqrt_arbiter.sv - round-robin sequencer for the shared psdsqrt datapath
//
// Grants one requester at a time, drives the datapath start/stop pulses,
// captures the 16-bit root and returns it with a per-requester done pulse.
//
// Ports:
//   clock          master clock, rising edge
//   reset          asynchronous active-low reset
//   req[NREQ]      request level per requester
//   xin_bus        operands, requester i at [32i+31:32i]
//   ack[NREQ]      one-cycle grant pulse (operand latched)
//   done[NREQ]     one-cycle completion pulse (result valid)
//   result[16]     last computed root, held until next completion
//   busy           high whenever the sequencer is not idle
//   sq_start       datapath start pulse
//   sq_stop        datapath stop pulse
//   sq_xin[32]     registered operand to the datapath
//   sq_sqrt[16]    root from the datapath
//   ops_done[16]   saturating completion count (only with PSDSQRT_ARB_CNT_EN)
//
// Build option: define PSDSQRT_ARB_CNT_EN to add the ops_done counter.

module psdsqrt_arbiter #(
  parameter int NREQ       = 4,
  parameter int RUN_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   xin_bus,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic [15:0]          result,
  output logic                 busy,
  output logic                 sq_start,
  output logic                 sq_stop,
  output logic [31:0]          sq_xin,
`ifdef PSDSQRT_ARB_CNT_EN
  output logic [15:0]          ops_done,
`endif
  input  logic [15:0]          sq_sqrt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(RUN_CYCLES);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_STOP,
    S_DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   last;
  logic [CW-1:0]   cnt;

  logic [IW-1:0]   pick;
  logic            pick_valid;
  int              cand;

  // Round-robin search starting just after the previous winner. The loop runs
  // from the farthest candidate to the nearest so the nearest hit is the one
  // left standing.
  always_comb begin
    pick       = last;
    pick_valid = 1'b0;
    cand       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = int'(last) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) begin
        pick       = IW'(cand);
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      last     <= IW'(NREQ - 1);
      cnt      <= '0;
      ack      <= '0;
      done     <= '0;
      result   <= '0;
      busy     <= 1'b0;
      sq_start <= 1'b0;
      sq_stop  <= 1'b0;
      sq_xin   <= '0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one state.
      ack      <= '0;
      done     <= '0;
      sq_start <= 1'b0;
      sq_stop  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state    <= S_START;
            idx      <= pick;
            last     <= pick;
            sq_xin   <= xin_bus[32*int'(pick) +: 32];
            sq_start <= 1'b1;
            ack      <= ONE << pick;
            busy     <= 1'b1;
          end
        end
        S_START: begin
          state <= S_RUN;
          cnt   <= CW'(RUN_CYCLES - 1);
        end
        S_RUN: begin
          if (cnt == '0) begin
            state   <= S_STOP;
            sq_stop <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          state <= S_DONE;
        end
        S_DONE: begin
          // The datapath root is stable here; done lands with the return to IDLE.
          state  <= S_IDLE;
          result <= sq_sqrt;
          done   <= ONE << idx;
          busy   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PSDSQRT_ARB_CNT_EN
  // Counts on the same edge that raises done, so the count and pulse align.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ops_done <= '0;
    end else if (state == S_DONE && ops_done != 16'hFFFF) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_psdsqrt_arbiter.sv
// tb/tb_psdsqrt_arbiter.sv - self-checking bench for psdsqrt_arbiter

module tb_psdsqrt_arbiter;

  localparam int NREQ       = 4;
  localparam int RUN_CYCLES = 16;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*32-1:0]  xin_bus = '0;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     done;
  logic [15:0]         result;
  logic                busy;
  logic                sq_start;
  logic                sq_stop;
  logic [31:0]         sq_xin;
  logic [15:0]         sq_sqrt = '0;
`ifdef PSDSQRT_ARB_CNT_EN
  logic [15:0]         ops_done;
`endif

  int compared   = 0;
  int mismatched = 0;
  int model_last = NREQ - 1;
  logic [31:0] dp_x = '0;

  always #5 clock = ~clock;

  psdsqrt_arbiter #(.NREQ(NREQ), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .xin_bus  (xin_bus),
    .ack      (ack),
    .done     (done),
    .result   (result),
    .busy     (busy),
    .sq_start (sq_start),
    .sq_stop  (sq_stop),
    .sq_xin   (sq_xin),
`ifdef PSDSQRT_ARB_CNT_EN
    .ops_done (ops_done),
`endif
    .sq_sqrt  (sq_sqrt)
  );

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > longint'(x)) r--;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return r[15:0];
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] r, input int lst);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (lst + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0 && i < NREQ) v[i] = 1'b1;
    return v;
  endfunction

  // Datapath stand-in: garbage until stop, true root afterwards.
  always @(posedge clock) begin
    if (sq_start) begin
      dp_x    <= sq_xin;
      sq_sqrt <= 16'($urandom);
    end else if (sq_stop) begin
      sq_sqrt <= isqrt(dp_x);
    end
  end

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_last = NREQ - 1;
  endtask

  // Counts negedges until the selected event; n = -1 on timeout.
  task automatic wait_for(input int which, input int limit, output int n);
    bit hit;
    hit = 1'b0;
    n = -1;
    for (int i = 1; i <= limit && !hit; i++) begin
      @(negedge clock);
      if ((which == 0 && ack != '0) || (which == 1 && sq_stop) || (which == 2 && done != '0)) begin
        hit = 1'b1;
        n = i;
      end
    end
  endtask

  task automatic run_one(input int i, input logic [31:0] x);
    int n;
    xin_bus[32*i +: 32] = x;
    req = onehot(i);
    wait_for(0, 30, n);
    req = '0;
    wait_for(2, 30, n);
    model_last = i;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    compared++;
    if (ack !== '0 || done !== '0 || result !== '0 || busy !== 1'b0 ||
        sq_start !== 1'b0 || sq_stop !== 1'b0 || sq_xin !== '0)
      $display("FAIL reset_outputs: got ack=%h done=%h result=%h busy=%b start=%b stop=%b xin=%h, want all 0",
               ack, done, result, busy, sq_start, sq_stop, sq_xin);
    if (ack !== '0 || done !== '0 || result !== '0 || busy !== 1'b0 ||
        sq_start !== 1'b0 || sq_stop !== 1'b0 || sq_xin !== '0)
      mismatched++;
    do_reset();
  endtask

  task automatic test_single;
    int n;
    xin_bus = '0;
    xin_bus[31:0] = 32'h0000_0010;
    req = 4'b0001;
    wait_for(0, 5, n);
    compared++;
    if (n !== 1) begin
      mismatched++;
      $display("FAIL single_ack_cycle: got %0d want 1", n);
    end
    compared++;
    if (ack !== 4'b0001 || sq_start !== 1'b1 || busy !== 1'b1 || sq_xin !== 32'h10 || sq_stop !== 1'b0) begin
      mismatched++;
      $display("FAIL single_start: got ack=%b start=%b busy=%b xin=%h stop=%b want 0001 1 1 00000010 0",
               ack, sq_start, busy, sq_xin, sq_stop);
    end
    req = '0;
    model_last = 0;
    wait_for(1, 40, n);
    compared++;
    if (n !== RUN_CYCLES + 1 || ack !== '0 || done !== '0) begin
      mismatched++;
      $display("FAIL single_stop_cycle: got %0d after ack (ack=%b done=%b) want %0d", n, ack, done, RUN_CYCLES + 1);
    end
    wait_for(2, 10, n);
    compared++;
    if (n !== 2) begin
      mismatched++;
      $display("FAIL single_done_cycle: got %0d after stop want 2", n);
    end
    compared++;
    if (done !== 4'b0001 || result !== 16'h0004 || busy !== 1'b0 || sq_stop !== 1'b0) begin
      mismatched++;
      $display("FAIL single_done: got done=%b result=%h busy=%b want 0001 0004 0", done, result, busy);
    end
  endtask

  task automatic test_edges;
    logic [31:0] ops [3];
    logic [15:0] want [3];
    int n;
    ops  = '{32'h0, 32'h1, 32'hFFFF_FFFF};
    want = '{16'h0, 16'h1, 16'hFFFF};
    for (int t = 0; t < 3; t++) begin
      xin_bus[31:0] = ops[t];
      req = 4'b0001;
      wait_for(0, 30, n);
      req = '0;
      model_last = 0;
      wait_for(2, 40, n);
      compared++;
      if (n < 0 || done !== 4'b0001 || result !== want[t] || result !== isqrt(ops[t])) begin
        mismatched++;
        $display("FAIL edge_%0d: got done=%b result=%h want 0001 %h", t, done, result, want[t]);
      end
    end
  endtask

  task automatic test_contention;
    int exp_order [5];
    int n, e;
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    xin_bus = {32'h000F_4240, 32'h0000_2710, 32'h0000_0090, 32'h0000_0064};
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      e = ref_pick(req, model_last);
      wait_for(0, 30, n);
      compared++;
      if (ack !== onehot(e) || e !== exp_order[t] || (t > 0 && n !== 1)) begin
        mismatched++;
        $display("FAIL contention_grant_%0d: got ack=%b after %0d cycles want %b after 1", t, ack, n, onehot(exp_order[t]));
      end
      model_last = e;
      wait_for(2, 30, n);
      compared++;
      if (done !== onehot(e) || result !== isqrt(xin_bus[32*e +: 32])) begin
        mismatched++;
        $display("FAIL contention_done_%0d: got done=%b result=%0d want %b %0d",
                 t, done, result, onehot(e), isqrt(xin_bus[32*e +: 32]));
      end
    end
    req = '0;
  endtask

  task automatic test_withdraw;
    int n;
    bit seen2, done_seen, busy_bad;
    seen2 = 1'b0;
    done_seen = 1'b0;
    busy_bad = 1'b0;
    xin_bus[31:0] = 32'h0001_0000;
    req = 4'b0001;
    wait_for(0, 30, n);
    req = '0;
    model_last = 0;
    repeat (3) @(negedge clock);
    req = 4'b0100;
    @(negedge clock);
    req = '0;
    for (int i = 0; i < 30 && !done_seen; i++) begin
      @(negedge clock);
      if (ack[2]) seen2 = 1'b1;
      if (done != '0) done_seen = 1'b1;
    end
    compared++;
    if (!done_seen || done !== 4'b0001 || busy !== 1'b0 || result !== 16'd256) begin
      mismatched++;
      $display("FAIL withdraw_done: got done=%b busy=%b result=%0d want 0001 0 256", done, busy, result);
    end
    repeat (25) begin
      @(negedge clock);
      if (ack[2]) seen2 = 1'b1;
      if (busy) busy_bad = 1'b1;
    end
    compared++;
    if (seen2 || busy_bad) begin
      mismatched++;
      $display("FAIL withdraw_no_grant: got ack2_seen=%b busy_seen=%b want 0 0", seen2, busy_bad);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit stray;
    stray = 1'b0;
    xin_bus[31:0] = 32'h0000_0400;
    req = 4'b0001;
    wait_for(0, 30, n);
    req = '0;
    repeat (8) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    compared++;
    if (ack !== '0 || done !== '0 || result !== '0 || busy !== 1'b0 ||
        sq_start !== 1'b0 || sq_stop !== 1'b0 || sq_xin !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_outputs: got ack=%b done=%b result=%h busy=%b start=%b stop=%b xin=%h want all 0",
               ack, done, result, busy, sq_start, sq_stop, sq_xin);
    end
    @(negedge clock);
    reset = 1'b1;
    model_last = NREQ - 1;
    repeat (25) begin
      @(negedge clock);
      if (done != '0 || busy) stray = 1'b1;
    end
    compared++;
    if (stray) begin
      mismatched++;
      $display("FAIL reset_mid_quiet: got activity after abort want none");
    end
    xin_bus = {32'd49, 32'd36, 32'd25, 32'd81};
    req = 4'b1111;
    wait_for(0, 30, n);
    compared++;
    if (ack !== onehot(ref_pick(4'b1111, model_last))) begin
      mismatched++;
      $display("FAIL reset_mid_first_grant: got ack=%b want 0001", ack);
    end
    req = '0;
    model_last = 0;
    wait_for(2, 30, n);
    compared++;
    if (done !== 4'b0001 || result !== 16'd9) begin
      mismatched++;
      $display("FAIL reset_mid_result: got done=%b result=%0d want 0001 9", done, result);
    end
  endtask

  task automatic test_random;
    int n, e;
    logic [NREQ-1:0] m;
    logic [15:0] exp_res;
    for (int it = 0; it < 30; it++) begin
      if (req == '0) begin
        m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int j = 0; j < NREQ; j++) if (m[j]) xin_bus[32*j +: 32] = $urandom;
        req = m;
      end
      e = ref_pick(req, model_last);
      wait_for(0, 30, n);
      compared++;
      if (e < 0 || ack !== onehot(e) || sq_xin !== xin_bus[32*e +: 32]) begin
        mismatched++;
        $display("FAIL random_grant_%0d: got ack=%b xin=%h want %b", it, ack, sq_xin, onehot(e));
      end
      if (e < 0) e = 0;
      exp_res = isqrt(xin_bus[32*e +: 32]);
      model_last = e;
      req[e] = 1'b0;
      m = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~req;
      for (int j = 0; j < NREQ; j++) if (m[j]) xin_bus[32*j +: 32] = $urandom;
      req = req | m;
      wait_for(2, 30, n);
      compared++;
      if (done !== onehot(e) || result !== exp_res) begin
        mismatched++;
        $display("FAIL random_done_%0d: got done=%b result=%h want %b %h", it, done, result, onehot(e), exp_res);
      end
    end
    req = '0;
    repeat (2) @(negedge clock);
  endtask

`ifdef PSDSQRT_ARB_CNT_EN
  task automatic test_counter;
    do_reset();
    compared++;
    if (ops_done !== 16'd0) begin
      mismatched++;
      $display("FAIL cnt_reset: got %0d want 0", ops_done);
    end
    for (int t = 0; t < 3; t++) run_one(t, 32'd100 + t);
    compared++;
    if (ops_done !== 16'd3) begin
      mismatched++;
      $display("FAIL cnt_three: got %0d want 3", ops_done);
    end
    force dut.ops_done = 16'hFFFD;
    @(negedge clock);
    release dut.ops_done;
    for (int t = 0; t < 3; t++) run_one(t, 32'd7);
    compared++;
    if (ops_done !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL cnt_saturate: got %h want ffff", ops_done);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_edges();
    test_contention();
    test_withdraw();
    test_reset_mid();
    test_random();
`ifdef PSDSQRT_ARB_CNT_EN
    test_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
